// File: rtl/eh2_lsu_trigger_hit_pkg.sv
// ----------------------------------------------------------------------------
// eh2_lsu_trigger_hit_pkg
// Shared types and constants for the LSU trigger-hit slice.
//   NUM_THREADS   : number of hardware threads
//   TID_W         : width of a thread ID
//   NUM_LSU_TRIG  : number of data triggers compared by the LSU
//   eh2_lsu_pkt_t : the subset of the DC4 LSU packet used here
//   eh2_lsu_trig_pend_t : one pending DC5 trigger entry
//   trig_state_e  : per-thread pending-entry state
// ----------------------------------------------------------------------------
package eh2_lsu_trigger_hit_pkg;

    localparam int NUM_THREADS  = 2;
    localparam int TID_W        = 1;
    localparam int NUM_LSU_TRIG = 4;

    typedef struct packed {
        logic             valid;
        logic [TID_W-1:0] tid;
        logic             dma;
    } eh2_lsu_pkt_t;

    typedef struct packed {
        logic                    valid;
        logic [NUM_LSU_TRIG-1:0] hit;
        logic                    action;
    } eh2_lsu_trig_pend_t;

    typedef enum logic {
        TRIG_IDLE = 1'b0,
        TRIG_PEND = 1'b1
    } trig_state_e;

endpackage

// File: rtl/eh2_lsu_trigger_hit_if.sv
// ----------------------------------------------------------------------------
// eh2_lsu_trigger_hit_if
// Bundles the DC4 trigger inputs, TLU/CSR controls and the DC5 outputs of the
// trigger-hit block.
//   master : the LSU/TLU side that drives matches, flushes, acks and clears
//   slave  : the trigger-hit block itself
// ----------------------------------------------------------------------------
interface eh2_lsu_trigger_hit_if;
    import eh2_lsu_trigger_hit_pkg::*;

    logic [NUM_LSU_TRIG-1:0]                   lsu_trigger_match_dc4;
    eh2_lsu_pkt_t                              lsu_pkt_dc4;
    logic [NUM_THREADS-1:0][1:0]               trig_chain;
    logic [NUM_THREADS-1:0][NUM_LSU_TRIG-1:0]  trig_action;
    logic [NUM_THREADS-1:0]                    flush_dc4;
    logic [NUM_THREADS-1:0]                    flush_pend;
    logic [NUM_THREADS-1:0][NUM_LSU_TRIG-1:0]  hit_clr;
    logic [NUM_THREADS-1:0]                    trig_ack;

    logic [NUM_THREADS-1:0]                    lsu_trigger_pend;
    logic [NUM_THREADS-1:0][NUM_LSU_TRIG-1:0]  lsu_trigger_hit_dc5;
    logic [NUM_THREADS-1:0]                    lsu_trigger_action_dc5;
    logic [NUM_THREADS-1:0][NUM_LSU_TRIG-1:0]  lsu_trigger_sticky;

    modport master (
        output lsu_trigger_match_dc4, lsu_pkt_dc4, trig_chain, trig_action,
               flush_dc4, flush_pend, hit_clr, trig_ack,
        input  lsu_trigger_pend, lsu_trigger_hit_dc5, lsu_trigger_action_dc5,
               lsu_trigger_sticky
    );

    modport slave (
        input  lsu_trigger_match_dc4, lsu_pkt_dc4, trig_chain, trig_action,
               flush_dc4, flush_pend, hit_clr, trig_ack,
        output lsu_trigger_pend, lsu_trigger_hit_dc5, lsu_trigger_action_dc5,
               lsu_trigger_sticky
    );

endinterface

// File: rtl/eh2_lsu_trigger_hit_chain.sv
// ----------------------------------------------------------------------------
// eh2_lsu_trigger_hit_chain
// Resolves chained trigger pairs (0/1 and 2/3). A chained pair only fires when
// both members match, and then reports both bits.
//   match_i : raw per-trigger match
//   chain_i : [0] pair 0/1 chained, [1] pair 2/3 chained
//   res_o   : resolved trigger vector
// ----------------------------------------------------------------------------
module eh2_lsu_trigger_hit_chain
    import eh2_lsu_trigger_hit_pkg::*;
(
    input  logic [NUM_LSU_TRIG-1:0] match_i,
    input  logic [1:0]              chain_i,
    output logic [NUM_LSU_TRIG-1:0] res_o
);

    always_comb begin
        res_o = match_i;
        if (chain_i[0]) begin
            res_o[1:0] = {2{match_i[0] & match_i[1]}};
        end
        if (chain_i[1]) begin
            res_o[3:2] = {2{match_i[2] & match_i[3]}};
        end
    end

endmodule

// File: rtl/eh2_lsu_trigger_hit.sv
// ----------------------------------------------------------------------------
// eh2_lsu_trigger_hit
// Takes the DC4 LSU trigger match, resolves chaining, and registers one
// pending trigger per thread into DC5 until the TLU acks it or it is flushed.
// Also keeps the per-thread sticky hit bits behind mcontrol.hit.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : slave side of eh2_lsu_trigger_hit_if (DC4 inputs, controls,
//              DC5 pending/hit/action outputs and sticky bits)
// ----------------------------------------------------------------------------
module eh2_lsu_trigger_hit
    import eh2_lsu_trigger_hit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    eh2_lsu_trigger_hit_if.slave   bus
);

    logic [TID_W-1:0]                         tid;
    logic [NUM_LSU_TRIG-1:0]                  res;
    logic                                     pktQual;
    logic [NUM_THREADS-1:0]                   pendVec;
    logic [NUM_THREADS-1:0]                   actVec;
    logic [NUM_THREADS-1:0][NUM_LSU_TRIG-1:0] hitVec;
    logic [NUM_THREADS-1:0][NUM_LSU_TRIG-1:0] stickyVec;

    assign tid = bus.lsu_pkt_dc4.tid;

    // Only one DC4 packet exists per cycle, so one resolver serves all threads
    // using the chain configuration of the packet's thread.
    eh2_lsu_trigger_hit_chain u_chain (
        .match_i (bus.lsu_trigger_match_dc4),
        .chain_i (bus.trig_chain[tid]),
        .res_o   (res)
    );

    // DMA accesses never raise triggers.
    assign pktQual = bus.lsu_pkt_dc4.valid & ~bus.lsu_pkt_dc4.dma & (|res);

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        trig_state_e             state_q;
        eh2_lsu_trig_pend_t      pend_q;
        logic [NUM_LSU_TRIG-1:0] sticky_q;
        logic [NUM_LSU_TRIG-1:0] sticky_d;
        logic                    hit4;
        logic                    capture;

        assign hit4    = pktQual & (tid == TID_W'(t)) & ~bus.flush_dc4[t];
        // An occupied slot drops new hits, including the cycle it is released.
        assign capture = hit4 & (state_q == TRIG_IDLE);

        // The hit is newer than any CSR write in the same cycle, so set wins.
        assign sticky_d = (sticky_q & ~bus.hit_clr[t]) | (capture ? res : '0);

        // Pending-entry FSM with the entry itself as registered output.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= TRIG_IDLE;
                pend_q   <= '0;
                sticky_q <= '0;
            end else begin
                sticky_q <= sticky_d;
                case (state_q)
                    TRIG_IDLE: begin
                        if (capture) begin
                            state_q       <= TRIG_PEND;
                            pend_q.valid  <= 1'b1;
                            pend_q.hit    <= res;
                            pend_q.action <= |(res & bus.trig_action[t]);
                        end
                    end
                    TRIG_PEND: begin
                        if (bus.trig_ack[t] | bus.flush_pend[t]) begin
                            state_q <= TRIG_IDLE;
                            pend_q  <= '0;
                        end
                    end
                    default: begin
                        state_q <= TRIG_IDLE;
                        pend_q  <= '0;
                    end
                endcase
            end
        end

        assign pendVec[t]   = pend_q.valid;
        assign hitVec[t]    = pend_q.hit;
        assign actVec[t]    = pend_q.action;
        assign stickyVec[t] = sticky_q;
    end

    assign bus.lsu_trigger_pend       = pendVec;
    assign bus.lsu_trigger_hit_dc5    = hitVec;
    assign bus.lsu_trigger_action_dc5 = actVec;
    assign bus.lsu_trigger_sticky     = stickyVec;

endmodule

// File: doc/eh2_lsu_trigger_hit.md
Name: eh2_lsu_trigger_hit

Overview:
- Downstream consumer of the LSU data-trigger match vector produced in DC4.
- Resolves chained trigger pairs (0/1, 2/3) and registers the result into DC5 with thread ID and action.
- Holds one pending trigger per thread until the TLU acknowledges it or the thread is flushed.
- Maintains per-thread sticky hit bits that back the mcontrol.hit CSR field.

Parameters:
- NUM_THREADS, 2, number of hardware threads (pt.NUM_THREADS); tid width is 1.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- lsu_trigger_match_dc4  in  4  raw per-trigger match from the LSU trigger compare
- lsu_pkt_dc4  in  eh2_lsu_pkt_t  DC4 packet; uses valid, tid, dma
- trig_chain  in  NUM_THREADS x 2  per thread: [0] trigger0 chains to 1, [1] trigger2 chains to 3
- trig_action  in  NUM_THREADS x 4  per-trigger action: 1=enter debug, 0=breakpoint exception
- flush_dc4  in  NUM_THREADS  kill the DC4 instruction of that thread
- flush_pend  in  NUM_THREADS  kill the pending DC5 entry of that thread
- hit_clr  in  NUM_THREADS x 4  CSR write clearing sticky hit bits
- trig_ack  in  NUM_THREADS  TLU consumed the pending entry
- lsu_trigger_pend  out  NUM_THREADS  pending entry valid per thread
- lsu_trigger_hit_dc5  out  NUM_THREADS x 4  resolved trigger vector of the pending entry
- lsu_trigger_action_dc5  out  NUM_THREADS  1=debug halt, 0=breakpoint
- lsu_trigger_sticky  out  NUM_THREADS x 4  sticky hit bits

Behaviour:
- Reset (rst=1 at a clk edge): all outputs and state are 0.
- Chain resolution, combinational in DC4, using thread t = lsu_pkt_dc4.tid:
  - If trig_chain[t][0]: res[1:0] = {2{m[0]&m[1]}}; else res[1:0] = m[1:0].
  - If trig_chain[t][1]: res[3:2] = {2{m[2]&m[3]}}; else res[3:2] = m[3:2].
- Qualified DC4 hit: hit4 = lsu_pkt_dc4.valid & ~lsu_pkt_dc4.dma & ~flush_dc4[t] & |res.
- Capture: on hit4 with lsu_trigger_pend[t]=0, the next cycle has lsu_trigger_pend[t]=1, lsu_trigger_hit_dc5[t]=res, and action = |(res & trig_action[t]). Latency is 1 cycle.
- Hold: the pending entry is held unchanged until trig_ack[t] or flush_pend[t]; either clears pend, hit and action to 0 on the next edge.
- Pending occupied: a new hit4 for thread t while pend[t]=1 is dropped, because the older instruction has priority. A same-cycle ack/flush and new hit4 for the same thread also drops the new hit; the entry is empty for one cycle.
- Threads are independent: a hit on thread 0 never alters thread 1 state.
- Per-thread state machine: IDLE -> PEND on capture; PEND -> IDLE on ack|flush_pend; reset forces IDLE.
- Sticky bits:
  - On capture, sticky[t] |= res.
  - hit_clr[t][i] clears bit i next cycle.
  - If set and clear hit the same bit in the same cycle, set wins (the hit is newer than the CSR write).
  - Sticky bits are not cleared by flush or ack.
- A DC4 flush or DMA access never touches sticky bits.
- trig_ack with pend=0 is ignored.

Decomposition:
- eh2_pkg: reuse eh2_lsu_pkt_t; add localparam NUM_LSU_TRIG=4 and typedef eh2_lsu_trig_pend_t {valid, hit[3:0], action}.
- One sub-module, eh2_lsu_trigger_chain: combinational pair resolution, instantiated once.
- The per-thread pend/sticky registers are a generate loop over NUM_THREADS using rvdffs with sync reset.

Test Plan:
- Basic capture: tid0 valid, match=4'b0010, no chain, action=0 -> next cycle pend[0]=1, hit[0]=0010, action[0]=0, sticky[0]=0010.
- Chaining: tid1, chain[1]=2'b01, match=4'b0001 -> no capture. match=4'b0011 with action[1]=4'b0010 -> hit[1]=0011, action[1]=1.
- Hold and drop: tid0 pending, new tid0 match=4'b1000 -> entry unchanged at the old value and sticky gains no bit 3. Then ack[0] -> pend[0]=0 next cycle.
- Flush and DMA: flush_dc4[0] or dma=1 with match=4'b1111 -> no pend, no sticky change. flush_pend[1] while pending -> cleared next cycle.
- Sticky clear race: sticky[0]=0100, hit_clr[0]=0100 in the same cycle as a capture of 0100 -> sticky stays 0100. hit_clr alone -> 0000.
- Reset mid-operation: both threads pending with sticky set, rst=1 for one cycle -> all outputs 0. Capture resumes normally after rst deasserts.
